// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: control encoding, FSM states, ALUOp constants.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

  // Operation selected by the decoder and carried through the sequencer
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctl_t;

  // Sequencer states: waiting, iterating a shift, holding a result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // ALUOp field values
  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

  // Shifts are the only operations that may need more than one cycle
  function automatic logic is_shift(input alu_ctl_t c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Translates ALUOp/funct3/funct7_5/op5 into a 4-bit ALU control code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [1:0] ALUOp,
  output logic [3:0] ALUControl
);

  alu_ctl_t ctl;

  // Decode table; ALUOp 10 defers to funct3, the rest force ADD or SUB
  always_comb begin
    ctl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD, ALUOP_ADD_ALT: ctl = ALU_ADD;
      ALUOP_SUB:                ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctl = ALU_SLL;
          3'b010:  ctl = ALU_SLT;
          3'b011:  ctl = ALU_SLTU;
          3'b100:  ctl = ALU_XOR;
          3'b101:  ctl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctl = ALU_OR;
          default: ctl = ALU_AND;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
  end

  assign ALUControl = ctl;

endmodule

// File: rtl/alu_exec_unit.sv
// Integer ALU with an iterative shifter and valid/ready handshakes on both sides.
// Latency: 1 cycle for non-shift ops and zero-distance shifts, 1 + ceil(shamt/SHIFT_STEP) for shifts.
// Backpressure: result held in DONE until out_ready; new request accepted in DONE on the same edge it drains.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            op5,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  // One extra bit so that SHIFT_STEP == XLEN is representable
  localparam logic [SHW:0] STEP_W = (SHW + 1)'(SHIFT_STEP);

  state_t          state, state_nxt;
  alu_ctl_t        ctl_q, ctl_nxt, in_ctl;
  logic [3:0]      dec_ctl;
  logic [XLEN-1:0] res_q, res_nxt, shifted;
  logic            zero_q, zero_nxt;
  logic [SHW:0]    cnt_q, cnt_nxt, step;
  logic [SHW-1:0]  shamt_in;
  logic            accept;

  alu_op_decoder u_dec (
    .op5        (op5),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .ALUOp      (ALUOp),
    .ALUControl (dec_ctl)
  );

  assign in_ctl   = alu_ctl_t'(dec_ctl);
  assign shamt_in = src_b[SHW-1:0];

  // Single-cycle result for everything except multi-step shifts; a
  // zero-distance shift simply passes src_a through.
  function automatic logic [XLEN-1:0] alu_eval(input alu_ctl_t c,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = a;
    case (c)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  begin r = '0; r[0] = $signed(a) < $signed(b); end
      ALU_SLTU: begin r = '0; r[0] = a < b; end
      default:  r = a;
    endcase
    return r;
  endfunction

  assign in_ready  = rst_n & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign result    = res_q;
  assign zero      = zero_q;

  // One shift step: move by min(remaining, SHIFT_STEP); SRA keeps the sign bit
  always_comb begin
    step    = (cnt_q >= STEP_W) ? STEP_W : cnt_q;
    shifted = res_q >> step;
    case (ctl_q)
      ALU_SLL: shifted = res_q << step;
      ALU_SRA: shifted = XLEN'($signed(res_q) >>> step);
      default: shifted = res_q >> step;
    endcase
  end

  // Next-state and datapath selection for the IDLE/SHIFT/DONE sequencer
  always_comb begin
    state_nxt = state;
    res_nxt   = res_q;
    zero_nxt  = zero_q;
    cnt_nxt   = cnt_q;
    ctl_nxt   = ctl_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          ctl_nxt = in_ctl;
          if (is_shift(in_ctl) && (shamt_in != '0)) begin
            state_nxt = ST_SHIFT;
            res_nxt   = src_a;
            zero_nxt  = (src_a == '0);
            cnt_nxt   = {1'b0, shamt_in};
          end else begin
            state_nxt = ST_DONE;
            res_nxt   = alu_eval(in_ctl, src_a, src_b);
            zero_nxt  = (res_nxt == '0);
            cnt_nxt   = '0;
          end
        end else if ((state == ST_DONE) && out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_nxt  = shifted;
        zero_nxt = (shifted == '0);
        cnt_nxt  = cnt_q - step;
        if (cnt_nxt == '0) state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      res_q  <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      ctl_q  <= ALU_ADD;
    end else begin
      state  <= state_nxt;
      res_q  <= res_nxt;
      zero_q <= zero_nxt;
      cnt_q  <= cnt_nxt;
      ctl_q  <= ctl_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: two instances (SHIFT_STEP 1 and 4), vector table, random ops vs model.
// Latency: checked per operation against the model's expected cycle count.
// Backpressure: exercised by a hand-written hold/drain sequence.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  aluop;
  logic [2:0]  funct3;
  logic        op5;
  logic        funct7_5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_ready;
  logic        in_valid_v  [2];
  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [31:0] result_w    [2];
  logic        zero_w      [2];
  logic        busy_w      [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          d;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        o5;
    logic        f75;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vt [18];

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .ALUOp(aluop), .funct3(funct3), .op5(op5), .funct7_5(funct7_5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .result(result_w[0]), .zero(zero_w[0]), .busy(busy_w[0])
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .ALUOp(aluop), .funct3(funct3), .op5(op5), .funct7_5(funct7_5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .result(result_w[1]), .zero(zero_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: result from the instruction semantics, latency from the cycle-count rule
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                                input logic f75, input logic [31:0] a, input logic [31:0] b,
                                input int stp, output logic [31:0] r, output int lat);
    int sh;
    bit is_sh;
    sh    = int'(b[4:0]);
    is_sh = 0;
    r     = a + b;
    if (op == 2'b01) r = a - b;
    else if (op == 2'b10) begin
      case (f3)
        3'd0: r = (o5 && f75) ? a - b : a + b;
        3'd1: begin r = a << sh; is_sh = 1; end
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin r = f75 ? 32'($signed(a) >>> sh) : a >> sh; is_sh = 1; end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    lat = (is_sh && sh > 0) ? 1 + (sh + stp - 1) / stp : 1;
  endfunction

  // Issue one op on instance d (called just after a rising edge, DUT idle, out_ready=1)
  task automatic run_op(input int d, input logic [1:0] op, input logic [2:0] f3,
                        input logic o5, input logic f75, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int el,
                        input string nm);
    int lat;
    aluop = op; funct3 = f3; op5 = o5; funct7_5 = f75; src_a = a; src_b = b;
    in_valid_v[d] = 1'b1;
    @(negedge clk);
    check({nm, " in_ready"}, 64'(in_ready_w[d]), 64'd1);
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    aluop = 2'($urandom); funct3 = 3'($urandom); op5 = 1'($urandom);
    funct7_5 = 1'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (out_valid_w[d]) begin lat = c; break; end
      if (c == 1 && busy_w[d] !== 1'b1) check({nm, " busy"}, 64'(busy_w[d]), 64'd1);
    end
    check({nm, " latency"}, 64'(lat), 64'(el));
    check({nm, " result"}, 64'(result_w[d]), 64'(er));
    check({nm, " zero"}, 64'(zero_w[d]), 64'(er == 32'd0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] er;
    int          el;
    int          d;
    logic [31:0] held;
    bit          seen;

    vt[0]  = '{0, 2'b00, 3'd0, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       1};
    vt[1]  = '{0, 2'b01, 3'd0, 1'b0, 1'b0, 32'h1234,     32'h1234,     32'd0,        1};
    vt[2]  = '{0, 2'b10, 3'd3, 1'b0, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd1,        1};
    vt[3]  = '{0, 2'b10, 3'd2, 1'b0, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        1};
    vt[4]  = '{0, 2'b10, 3'd5, 1'b0, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 5};
    vt[5]  = '{1, 2'b10, 3'd5, 1'b0, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 2};
    vt[6]  = '{0, 2'b11, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1};
    vt[7]  = '{0, 2'b10, 3'd0, 1'b1, 1'b1, 32'd10,       32'd3,        32'd7,        1};
    vt[8]  = '{0, 2'b10, 3'd0, 1'b0, 1'b1, 32'd10,       32'd3,        32'd13,       1};
    vt[9]  = '{0, 2'b10, 3'd4, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1};
    vt[10] = '{0, 2'b10, 3'd6, 1'b0, 1'b0, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1};
    vt[11] = '{0, 2'b10, 3'd7, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    vt[12] = '{0, 2'b10, 3'd1, 1'b0, 1'b0, 32'h0000ABCD, 32'h00000020, 32'h0000ABCD, 1};
    vt[13] = '{0, 2'b10, 3'd5, 1'b0, 1'b0, 32'h80000000, 32'd31,       32'd1,        32};
    vt[14] = '{1, 2'b10, 3'd5, 1'b0, 1'b0, 32'h80000000, 32'd31,       32'd1,        9};
    vt[15] = '{1, 2'b10, 3'd1, 1'b0, 1'b0, 32'd1,        32'd7,        32'h00000080, 3};
    vt[16] = '{0, 2'b01, 3'd0, 1'b0, 1'b0, 32'd0,        32'd1,        32'hFFFFFFFF, 1};
    vt[17] = '{1, 2'b10, 3'd5, 1'b0, 1'b1, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 9};

    // Reset: request pending on both instances must not be taken
    rst_n = 1'b0; out_ready = 1'b1;
    aluop = 2'b00; funct3 = 3'd0; op5 = 1'b0; funct7_5 = 1'b0; src_a = 32'd1; src_b = 32'd2;
    in_valid_v[0] = 1'b1; in_valid_v[1] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst out_valid", 64'(out_valid_w[0]), 64'd0);
      check("rst in_ready", 64'(in_ready_w[0]), 64'd0);
      check("rst in_ready s4", 64'(in_ready_w[1]), 64'd0);
    end
    check("rst result", 64'(result_w[0]), 64'd0);
    check("rst zero", 64'(zero_w[0]), 64'd0);
    check("rst busy", 64'(busy_w[0]), 64'd0);
    rst_n = 1'b1; in_valid_v[0] = 1'b0; in_valid_v[1] = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 64'(in_ready_w[0]), 64'd1);
    check("post-rst out_valid", 64'(out_valid_w[0]), 64'd0);
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 18; i++)
      run_op(vt[i].d, vt[i].op, vt[i].f3, vt[i].o5, vt[i].f75, vt[i].a, vt[i].b,
             vt[i].r, vt[i].lat, $sformatf("vec%0d", i));

    // Backpressure: hold result three cycles, then drain and accept on the same edge
    out_ready = 1'b0;
    aluop = 2'b00; funct3 = 3'd0; src_a = 32'd10; src_b = 32'd20; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    check("bp out_valid", 64'(out_valid_w[0]), 64'd1);
    held = 32'd30;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("bp hold result", 64'(result_w[0]), 64'(held));
      check("bp hold in_ready", 64'(in_ready_w[0]), 64'd0);
      check("bp hold out_valid", 64'(out_valid_w[0]), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; aluop = 2'b01; src_a = 32'd50; src_b = 32'd8; in_valid_v[0] = 1'b1;
    @(negedge clk);
    check("bp drain in_ready", 64'(in_ready_w[0]), 64'd1);
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    check("bp next out_valid", 64'(out_valid_w[0]), 64'd1);
    check("bp next result", 64'(result_w[0]), 64'd42);
    @(posedge clk); #1;

    // Reset in the middle of a 20-position left shift
    aluop = 2'b10; funct3 = 3'd1; funct7_5 = 1'b0; src_a = 32'd1; src_b = 32'd20;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy before", 64'(busy_w[0]), 64'd1);
    @(posedge clk); #1;
    check("midrst busy after", 64'(busy_w[0]), 64'd0);
    check("midrst result", 64'(result_w[0]), 64'd0);
    check("midrst in_ready", 64'(in_ready_w[0]), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid_w[0]) seen = 1;
    end
    check("midrst no out_valid", 64'(seen), 64'd0);
    check("midrst idle in_ready", 64'(in_ready_w[0]), 64'd1);
    @(posedge clk); #1;

    // Random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  rop;
      logic [2:0]  rf3;
      logic        ro5, rf75;
      logic [31:0] ra, rb;
      d    = int'($urandom_range(1, 0));
      rop  = 2'($urandom); rf3 = 3'($urandom); ro5 = 1'($urandom); rf75 = 1'($urandom);
      ra   = $urandom; rb = $urandom;
      if (i % 7 == 0) ra = 32'd0;
      if (i % 5 == 0) rb = ra;
      model(rop, rf3, ro5, rf75, ra, rb, (d == 0) ? 1 : 4, er, el);
      run_op(d, rop, rf3, ro5, rf75, ra, rb, er, el, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SHIFT_STEP, default 1, maximum bit positions shifted per cycle; power of two, 1..XLEN.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: operation request handshake.
REQ-006 SHALL have ports ALUOp input 2, funct3 input 3, op5 input 1, funct7_5 input 1: instruction decode fields.
REQ-007 SHALL have ports src_a input XLEN and src_b input XLEN: operands; the shift amount is src_b[log2(XLEN)-1:0].
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-009 SHALL have ports result output XLEN, zero output 1 (result == 0), and busy output 1 (state is not IDLE).

Function
REQ-010 Decode SHALL be: ALUOp 00 -> ADD; 01 -> SUB; 11 -> ADD.
REQ-011 With ALUOp 10, funct3 SHALL decode as follows:
- 000: SUB if op5 & funct7_5, else ADD.
- 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR.
- 101: SRA if funct7_5, else SRL.
- 110 OR; 111 AND.
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 in IDLE, and in DONE when out_ready = 1; otherwise 0, including while rst_n = 0.
REQ-014 Decode fields and operands SHALL be captured on the accept edge (in_valid & in_ready); input changes after acceptance SHALL have no effect.
REQ-015 Non-shift operations and shifts with shamt = 0 SHALL go to DONE with the registered result; out_valid = 1 on the cycle after acceptance (latency 1).
REQ-016 A shift with shamt > 0 SHALL go to SHIFT; each cycle it shifts by min(remaining, SHIFT_STEP) and reaches DONE when remaining = 0.
REQ-017 Shift latency SHALL be 1 + ceil(shamt / SHIFT_STEP) cycles; SRA SHALL replicate src_a[XLEN-1] on every step.
REQ-018 ADD/SUB SHALL wrap modulo 2^XLEN with no carry or overflow output; SLT/SLTU SHALL produce a result of 0 or 1, zero-extended.
REQ-019 In DONE, result and zero SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-020 Handshake in DONE: out_ready = 1 without in_valid -> IDLE; out_ready = 1 with in_valid -> accept the new request on the same edge (throughput 1 per cycle for latency-1 operations).
REQ-021 in_valid SHALL be ignored in SHIFT; busy = 1 in SHIFT and DONE.

Reset
REQ-022 While rst_n = 0 at a rising edge, the block SHALL reset to: state IDLE, out_valid 0, result 0, zero 0, shift counter 0.
REQ-023 Reset asserted during SHIFT or DONE SHALL discard the operation; no out_valid SHALL follow the reset.
REQ-024 No output SHALL change asynchronously to clk.

Structure
REQ-025 Shared package alu_pkg SHALL hold:
- the ALUControl encoding (4 bits): ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001;
- the FSM state encoding;
- the ALUOp constants.
REQ-026 Decode SHALL be a combinational sub-module alu_op_decoder (inputs op5, funct3, funct7_5, ALUOp; output 4-bit ALUControl), instantiated once.

Verification
REQ-027 Reset: rst_n = 0 for 2 cycles, then 1 -> out_valid = 0 and in_ready = 0 during reset; in_ready = 1 on the first cycle after release.
REQ-028 ADD/SUB: ALUOp = 00, a = 5, b = 7 -> one cycle later result = 12, zero = 0; ALUOp = 01, a = b = 0x1234 -> result = 0, zero = 1.
REQ-029 SRA: ALUOp = 10, funct3 = 101, funct7_5 = 1, a = 0x80000000, b = 4, SHIFT_STEP = 1 -> out_valid 5 cycles after accept, result = 0xF8000000; with SHIFT_STEP = 4 -> 2 cycles.
REQ-030 Compare: funct3 = 011, a = 1, b = 0xFFFFFFFF -> result = 1; funct3 = 010 with the same operands -> result = 0.
REQ-031 Backpressure: out_ready = 0 for 3 cycles -> result stable and in_ready = 0; then out_ready = 1 with in_valid = 1 -> new request accepted on the same edge, and the next result appears the following cycle.
REQ-032 Reset mid-shift: SLL with b = 20; rst_n = 0 at cycle 3 -> IDLE next edge, out_valid never rises for that operation.
